apb_queued_master: RTL and testbench

APB_QUEUED_MASTER -- requirements
Module: apb_queued_master

---
 rtl/apb_queued_master.sv | 168 ++++++++++++++++
 tb/tb_apb_queued_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_queued_master.sv
// apb_queued_master: queued APB requester with a command FIFO, a 2-entry response buffer and an ACCESS timeout.
module apb_queued_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_write,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr,
  output logic [$clog2(DEPTH):0]    cmd_level,
  output logic                      busy
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = $clog2(DEPTH);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH + SW;
  localparam int RW = DATA_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cmd_mem [DEPTH];
  logic [RW-1:0]         rsp_mem [2];
  logic [LW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [LW:0]           lvl_q, lvl_d;
  logic                  rdy_q, rdy_d;
  logic                  rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [1:0]            rsp_cnt_q, rsp_cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic                  h_write;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [SW-1:0]         h_strb;
  logic                  push, start, tmo_hit, done, rsp_pop;
  logic [RW-1:0]         rsp_entry;

  assign {h_write, h_addr, h_wdata, h_strb} = cmd_mem[rd_q];
  assign push      = cmd_valid & rdy_q;
  assign rsp_pop   = (rsp_cnt_q != 2'd0) & rsp_ready;
  assign tmo_hit   = (TIMEOUT != 0) && state_q == ACCESS && !pready && tmo_q == TW'(TIMEOUT - 1);
  assign done      = state_q == ACCESS && (pready || tmo_hit);
  // A timed-out transfer reports err with zero data regardless of what the completer drives.
  assign rsp_entry = {(pwrite_q | tmo_hit) ? '0 : prdata, pwrite_q, pslverr | tmo_hit, tmo_hit};
  // Launch only if the response buffer can still absorb this transfer's result after this edge.
  assign start     = lvl_q != '0 && rsp_cnt_d <= 2'd1 && (state_q == IDLE || done);

  always_comb begin
    wr_d      = push ? wr_q + LW'(1) : wr_q;
    rd_d      = start ? rd_q + LW'(1) : rd_q;
    lvl_d     = (push && !start) ? lvl_q + (LW+1)'(1) : (!push && start) ? lvl_q - (LW+1)'(1) : lvl_q;
    rdy_d     = lvl_d != (LW+1)'(DEPTH);
    rsp_wr_d  = done ? ~rsp_wr_q : rsp_wr_q;
    rsp_rd_d  = rsp_pop ? ~rsp_rd_q : rsp_rd_q;
    rsp_cnt_d = (done && !rsp_pop) ? rsp_cnt_q + 2'd1 : (!done && rsp_pop) ? rsp_cnt_q - 2'd1 : rsp_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    if (start) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = h_write;
      paddr_d   = h_addr;
      pwdata_d  = h_write ? h_wdata : '0;
      pstrb_d   = h_write ? h_strb : '0;
    end else if (state_q == SETUP) begin
      state_d   = ACCESS;
      penable_d = 1'b1;
      tmo_d     = '0;
    end else if (state_q == ACCESS && !done) begin
      tmo_d     = tmo_q + TW'(1);
    end else if (state_q == ACCESS) begin
      state_d   = IDLE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      rdy_q     <= 1'b0;
      rsp_wr_q  <= 1'b0;
      rsp_rd_q  <= 1'b0;
      rsp_cnt_q <= '0;
      tmo_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      rdy_q     <= rdy_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      tmo_q     <= tmo_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
    if (done) rsp_mem[rsp_wr_q] <= rsp_entry;
  end

  assign cmd_ready = rdy_q;
  assign cmd_level = lvl_q;
  assign rsp_valid = rsp_cnt_q != 2'd0;
  assign {rsp_rdata, rsp_write, rsp_err, rsp_timeout} = rsp_mem[rsp_rd_q];
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign busy      = state_q != IDLE || lvl_q != '0 || rsp_cnt_q != 2'd0;
endmodule

// File: tb/tb_apb_queued_master.sv
// tb_apb_queued_master: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_apb_queued_master;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_write, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr = 0;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  cmd_level;
  logic        busy;
  int          checks = 0, errors = 0, wait_n = 1, acc = 0;
  logic [34:0] exp_q [$];

  apb_queued_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .cmd_level(cmd_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Completer: ready on the wait_n-th ACCESS cycle, never when wait_n is 0; read data is addr+1.
  always @(posedge clk) acc <= penable ? acc + 1 : 0;
  assign pready = (wait_n != 0) && (acc >= wait_n - 1);
  assign prdata = paddr + 32'd1;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got 0x%0h expected none", {rsp_rdata, rsp_write, rsp_err, rsp_timeout});
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_write, rsp_err, rsp_timeout} !== e) begin
          errors++;
          $display("FAIL rsp_payload: got 0x%0h expected 0x%0h", {rsp_rdata, rsp_write, rsp_err, rsp_timeout}, e);
        end
      end
    end
  end

  function automatic logic [34:0] r(input logic [31:0] d, input logic w, input logic er, input logic t);
    return {d, w, er, t};
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [34:0] e);
    logic ok;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int i = 0; i < 100; i++) begin
      ok = cmd_ready;
      cyc(1);
      if (ok) begin
        exp_q.push_back(e);
        cmd_valid = 0;
        return;
      end
    end
    cmd_valid = 0;
    chk("push_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && exp_q.size() == 0) return;
      cyc(1);
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int cnt, run, maxrun, bad, pcnt;
    logic prev, saw;
    #12;
    chk("rst_psel", psel, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", cmd_level, 0);
    @(negedge clk) rst_n = 1;
    cyc(1);
    chk("rel_cmd_ready", cmd_ready, 1);

    // single write, latency
    push(1, 32'h10, 32'hA5A5_5A5A, 4'hF, r(0, 1, 0, 0));
    cyc(1);
    chk("wr_setup_psel", {psel, penable, pwrite}, 3'b101);
    chk("wr_setup_paddr", paddr, 32'h10);
    chk("wr_setup_pwdata", pwdata, 32'hA5A5_5A5A);
    chk("wr_setup_pstrb", pstrb, 4'hF);
    cyc(1);
    chk("wr_access", {psel, penable}, 2'b11);
    cyc(1);
    chk("wr_rsp_latency", rsp_valid, 1);
    wait_idle();

    // four back-to-back reads
    cnt = 0; run = 0; maxrun = 0; bad = 0;
    fork
      for (int i = 0; i < 4; i++) push(0, 32'h20 + 32'(i * 4), 32'hFFFF_FFFF, 4'hF, r(32'h21 + 32'(i * 4), 0, 0, 0));
      repeat (14) begin
        @(negedge clk);
        cnt += psel ? 1 : 0;
        run = psel ? run + 1 : 0;
        maxrun = run > maxrun ? run : maxrun;
        bad += (psel && (pstrb != 0 || pwdata != 0)) ? 1 : 0;
      end
    join
    chk("b2b_psel_cycles", 64'(cnt), 8);
    chk("b2b_psel_run", 64'(maxrun), 8);
    chk("b2b_read_strb", 64'(bad), 0);
    wait_idle();

    // fill the FIFO while the completer stalls
    wait_n = 0;
    for (int i = 0; i < 5; i++) push(1, 32'h100 + 32'(i), 32'(i), 4'h3, r(0, 1, 0, 0));
    chk("full_level", cmd_level, 4);
    chk("full_ready", cmd_ready, 0);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h1FF; cmd_wdata = 32'h55; cmd_strb = 4'h1;
    cyc(3);
    chk("full_held_ready", cmd_ready, 0);
    chk("full_held_level", cmd_level, 4);
    wait_n = 1;
    push(1, 32'h1FF, 32'h55, 4'h1, r(0, 1, 0, 0));
    wait_idle();

    // timeout after 16 stalled ACCESS cycles
    wait_n = 0; pcnt = 0; prev = 0;
    push(0, 32'h40, 0, 4'hF, r(0, 0, 1, 1));
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      if (prev && !penable) chk("tmo_psel_drop", psel, 0);
      pcnt += penable ? 1 : 0;
      prev = penable;
    end
    chk("tmo_access_cycles", 64'(pcnt), 16);
    wait_idle();
    // ready on the 16th cycle completes normally
    wait_n = 16;
    push(0, 32'h44, 0, 4'hF, r(32'h45, 0, 0, 0));
    wait_idle();
    wait_n = 1; pslverr = 1;
    push(1, 32'h50, 32'h1234, 4'hC, r(0, 1, 1, 0));
    push(0, 32'h54, 0, 4'hF, r(32'h55, 0, 1, 0));
    wait_idle();
    pslverr = 0;

    // response back-pressure
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) push(0, 32'h60 + 32'(i * 4), 0, 4'hF, r(32'h61 + 32'(i * 4), 0, 0, 0));
    cyc(12);
    chk("bp_psel", psel, 0);
    chk("bp_level", cmd_level, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    wait_idle();

    // reset mid-transfer
    wait_n = 0;
    for (int i = 0; i < 3; i++) push(0, 32'h70 + 32'(i * 4), 0, 4'hF, r(0, 0, 0, 0));
    cyc(1);
    chk("mid_access", penable, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_psel", {psel, penable}, 0);
    chk("mid_rst_level", cmd_level, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    exp_q.delete();
    wait_n = 1;
    @(negedge clk) rst_n = 1;
    cyc(1);
    chk("mid_rel_ready", cmd_ready, 1);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      saw |= rsp_valid | psel;
      cyc(1);
    end
    chk("mid_no_activity", saw, 0);
    push(0, 32'h80, 0, 4'hF, r(32'h81, 0, 0, 0));
    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
